decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath/immediate width; legal values 32 and 64 only.
REQ-002 Ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-003 Ports: flush  in  1  discard all held entries; in_valid  in  1; in_ready  out  1; in_instr  in  32; in_pc  in  XLEN.
REQ-004 Ports: out_valid  out  1; out_ready  in  1; out_pc  out  XLEN; out_imm  out  XLEN; out_rs1/out_rs2/out_rd  out  5 each.
REQ-005 Ports: out_opcode  out  7; out_funct3  out  3; out_funct7  out  7; out_fmt  out  3, format code; out_illegal  out  1.

Function
REQ-006 Transfers SHALL occur only on valid&&ready, on both the input and the output side.
REQ-007 Latency SHALL be exactly 1 cycle: an input accepted at edge N appears on the outputs after edge N, with out_valid=1, when the stage was empty.
REQ-008 Buffering SHALL be a 2-entry skid (output register plus skid register).
REQ-009 in_ready SHALL be a registered signal equal to NOT skid_valid, with no combinational path from out_ready.
REQ-010 Backpressure: when out_valid && !out_ready and an input is accepted, the new entry SHALL go to the skid register.
REQ-011 When out_ready returns, the skid entry SHALL move to the output register on the next edge, and order SHALL be preserved.
REQ-012 Simultaneous output pop and input push with the skid empty SHALL load the output register directly, keeping full throughput of 1 per cycle.
REQ-013 Field extraction: opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
REQ-014 out_fmt codes: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
REQ-015 Opcode-to-format map: 0110011 is R; 0010011, 0000011, 1100111 and 1110011 are I; 0100011 is S; 1100011 is B; 0110111 and 0010111 are U; 1101111 is J; all others are NONE.
REQ-016 Immediates SHALL use the standard RV layouts, with I/S/B/J sign-extended from instr[31] to XLEN.
REQ-017 The U immediate SHALL be {instr[31:12],12'b0} sign-extended from bit 31 when XLEN=64.
REQ-018 R and NONE formats SHALL give out_imm=0.
REQ-019 flush SHALL clear both entries' valid bits on the next edge and SHALL take precedence over a same-cycle input or output handshake.
REQ-020 in_ready SHALL be 1 in the cycle after a flush.
REQ-021 Payload registers SHALL load only on accept, and SHALL hold their value while out_valid && !out_ready.

Reset
REQ-022 On rst=1 at an edge, out_valid=0, skid_valid=0 and in_ready=1.
REQ-023 On reset, all payload outputs SHALL be 0 and out_fmt=7.
REQ-024 Reset asserted mid-transfer SHALL drop both entries, and no transfer SHALL complete in that cycle.

Configuration
REQ-025 Macro DECODE_ILLEGAL_CHK_EN, when defined, SHALL set out_illegal=1 if any of the following hold: instr[1:0]!=2'b11; opcode is NONE and not 0001111; JALR with funct3!=0; R-type with funct7 not in {0000000, 0100000, 0000001}.
REQ-026 When the macro is undefined, out_illegal SHALL be constant 0 and no check logic SHALL be synthesised.
REQ-027 The illegal flag SHALL travel with its entry through the skid buffer.

Structure
REQ-028 Package decode_pkg SHALL hold the opcode constants, the fmt enum/codes and the payload struct typedef.
REQ-029 Sub-module decode_comb SHALL hold pure combinational field/immediate/format (and illegal) decode, feeding the skid-buffer registers in decode_stage.

Verification
REQ-030 Input 0xFFF00093 (addi x1,x0,-1) -> out_imm=0xFFFFFFFF, out_rd=1, out_fmt=1, out_illegal=0, one cycle later.
REQ-031 Input 0x00112623 (sw x1,12(x2)) -> out_imm=12, rs1=2, rs2=1, fmt=2.
REQ-032 Input 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC, fmt=3.
REQ-033 Input 0x123452B7 (lui x5) -> out_imm=0x12345000, rd=5, fmt=4.
REQ-034 With XLEN=64 and input 0x800000B7 -> out_imm=0xFFFFFFFF80000000.
REQ-035 Backpressure test: hold out_ready=0, push 3 instructions -> in_ready falls after the 2nd; releasing gives in-order output of the first two, then the third is accepted.
REQ-036 Flush test: flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed input is not presented.
REQ-037 With DECODE_ILLEGAL_CHK_EN defined, input 0x00000000 -> out_illegal=1; without the macro -> out_illegal=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: RV opcode constants, format codes, and the
// decoded-field payload carried through the decode stage skid buffer.
package decode_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    // Everything except pc/imm, whose width depends on XLEN.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        fmt_e       fmt;
        logic       illegal;
    } dec_fields_t;

    localparam dec_fields_t DEC_FIELDS_RST = '{
        opcode:  7'd0,
        funct3:  3'd0,
        funct7:  7'd0,
        rs1:     5'd0,
        rs2:     5'd0,
        rd:      5'd0,
        fmt:     FMT_NONE,
        illegal: 1'b0
    };

    function automatic fmt_e opcode_fmt(input logic [6:0] opcode);
        case (opcode)
            OP_OP:                                 return FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:   return FMT_I;
            OP_STORE:                              return FMT_S;
            OP_BRANCH:                             return FMT_B;
            OP_LUI, OP_AUIPC:                      return FMT_U;
            OP_JAL:                                return FMT_J;
            default:                               return FMT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32 instruction field, format and immediate decode.
// Optional illegal-instruction check enabled by macro DECODE_ILLEGAL_CHK_EN;
// without it the illegal flag is tied to 0.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output dec_fields_t     fields
);

    fmt_e              fmt;
    logic signed [31:0] imm32;

    // Widen a 32-bit signed immediate to XLEN, replicating bit 31.
    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    assign fmt = opcode_fmt(instr[6:0]);

    // Field slicing, immediate assembly per format, optional legality check.
    always_comb begin
        fields.opcode = instr[6:0];
        fields.rd     = instr[11:7];
        fields.funct3 = instr[14:12];
        fields.rs1    = instr[19:15];
        fields.rs2    = instr[24:20];
        fields.funct7 = instr[31:25];
        fields.fmt    = fmt;

        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm = sext32(imm32);

`ifdef DECODE_ILLEGAL_CHK_EN
        fields.illegal = (instr[1:0] != 2'b11)
                      || ((fmt == FMT_NONE) && (instr[6:0] != OP_FENCE))
                      || ((instr[6:0] == OP_JALR) && (instr[14:12] != 3'd0))
                      || ((fmt == FMT_R) && !((instr[31:25] == 7'b0000000)
                                            || (instr[31:25] == 7'b0100000)
                                            || (instr[31:25] == 7'b0000001)));
`else
        fields.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: combinational decode feeding a 2-entry skid buffer
// (output register + skid register). 1-cycle latency, full throughput,
// registered in_ready. XLEN must be 32 or 64.
// Optional illegal-instruction flag enabled by macro DECODE_ILLEGAL_CHK_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    logic [XLEN-1:0] dec_imm;
    dec_fields_t     dec_fields;

    logic            vld_p1;
    logic            skid_vld_p1;
    logic            rdy_p1;
    logic [XLEN-1:0] pc_p1;
    logic [XLEN-1:0] imm_p1;
    dec_fields_t     fld_p1;
    logic [XLEN-1:0] skid_pc_p1;
    logic [XLEN-1:0] skid_imm_p1;
    dec_fields_t     skid_fld_p1;

    logic in_acc;
    logic out_free;

    decode_comb #(.XLEN(XLEN)) u_comb (
        .instr  (in_instr),
        .imm    (dec_imm),
        .fields (dec_fields)
    );

    // The output register can take a new entry when empty or being popped.
    assign in_acc   = in_valid && rdy_p1;
    assign out_free = !vld_p1 || out_ready;

    // ---- stage p1: control (valid bits and registered ready) ----
    // Valid/ready bookkeeping; reset and flush drop both entries.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_p1      <= 1'b1;
        end else if (out_free) begin
            // Skid drains first; ready was low while it was full, so no accept then.
            vld_p1      <= skid_vld_p1 || in_acc;
            skid_vld_p1 <= 1'b0;
            rdy_p1      <= 1'b1;
        end else if (in_acc) begin
            skid_vld_p1 <= 1'b1;
            rdy_p1      <= 1'b0;
        end
    end

    // Output payload register: load from skid or directly from decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p1  <= '0;
            imm_p1 <= '0;
            fld_p1 <= DEC_FIELDS_RST;
        end else if (!flush && out_free) begin
            if (skid_vld_p1) begin
                pc_p1  <= skid_pc_p1;
                imm_p1 <= skid_imm_p1;
                fld_p1 <= skid_fld_p1;
            end else if (in_acc) begin
                pc_p1  <= in_pc;
                imm_p1 <= dec_imm;
                fld_p1 <= dec_fields;
            end
        end
    end

    // Skid payload register: captures an accept while the output is stalled.
    always_ff @(posedge clk) begin
        if (!rst && !flush && !out_free && in_acc) begin
            skid_pc_p1  <= in_pc;
            skid_imm_p1 <= dec_imm;
            skid_fld_p1 <= dec_fields;
        end
    end

    assign in_ready    = rdy_p1;
    assign out_valid   = vld_p1;
    assign out_pc      = pc_p1;
    assign out_imm     = imm_p1;
    assign out_rs1     = fld_p1.rs1;
    assign out_rs2     = fld_p1.rs2;
    assign out_rd      = fld_p1.rd;
    assign out_opcode  = fld_p1.opcode;
    assign out_funct3  = fld_p1.funct3;
    assign out_funct7  = fld_p1.funct7;
    assign out_fmt     = fld_p1.fmt;
    assign out_illegal = fld_p1.illegal;

endmodule
